// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: PDM clock generation, per-mic 3-stage CIC decimation and
// valid/ready streaming of one signed PCM word per mic per frame.
module pdm_cic_decimator #(
  parameter int NUM_MICS    = 9,
  parameter int PDM_CLK_DIV = 12,
  parameter int LOG2R       = 7,
  parameter int OUT_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MICS-1:0]         pdm,
  output logic                        pdm_clk,
  output logic                        pcm_valid,
  input  logic                        pcm_ready,
  output logic signed [OUT_WIDTH-1:0] pcm_data,
  output logic [4:0]                  pcm_mic,
  output logic                        pcm_last,
  output logic                        overrun
);
  localparam int ACC_W = 3*LOG2R+2;
  localparam int SHIFT = 3*LOG2R-(OUT_WIDTH-1);
  localparam int DIV_W = $clog2(PDM_CLK_DIV);
  localparam int IW = NUM_MICS > 1 ? $clog2(NUM_MICS) : 1;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(2**(OUT_WIDTH-1)-1);
  localparam logic signed [ACC_W-1:0] LO = ~HI;
  localparam logic [IW-1:0] LAST = IW'(NUM_MICS-1);
  typedef enum logic [1:0] {IDLE, COMB, OUT} state_t;
  state_t                      r_state;
  logic [DIV_W-1:0]            r_div;
  logic [LOG2R-1:0]            r_cnt;
  logic signed [ACC_W-1:0]     r_i1 [NUM_MICS];
  logic signed [ACC_W-1:0]     r_i2 [NUM_MICS];
  logic signed [ACC_W-1:0]     r_i3 [NUM_MICS];
  logic signed [ACC_W-1:0]     r_snap [NUM_MICS];
  logic signed [ACC_W-1:0]     r_d1 [NUM_MICS];
  logic signed [ACC_W-1:0]     r_d2 [NUM_MICS];
  logic signed [ACC_W-1:0]     r_d3 [NUM_MICS];
  logic signed [OUT_WIDTH-1:0] r_buf [NUM_MICS];
  logic [IW-1:0]               r_k, r_rd;
  logic                        r_drop;
  logic                        w_wrap, w_strobe, w_dec, w_proc, w_hi, w_lo;
  logic signed [ACC_W-1:0]     w_c1, w_c2, w_c3, w_sh;
  logic signed [OUT_WIDTH-1:0] w_sat;
  logic [IW-1:0]               w_nxt;
  assign w_wrap   = r_div == DIV_W'(PDM_CLK_DIV-1);
  assign w_strobe = w_wrap & pdm_clk;
  assign w_dec    = w_strobe & (&r_cnt);
  assign w_proc   = (r_state == COMB) | r_drop;
  assign w_c1     = r_snap[r_k] - r_d1[r_k];
  assign w_c2     = w_c1 - r_d2[r_k];
  assign w_c3     = w_c2 - r_d3[r_k];
  assign w_sh     = w_c3 >>> SHIFT;
  assign w_hi     = w_sh > HI;
  assign w_lo     = w_sh < LO;
  assign w_sat    = w_hi ? OUT_WIDTH'(HI) : w_lo ? OUT_WIDTH'(LO) : w_sh[OUT_WIDTH-1:0];
  assign w_nxt    = r_rd + 1'b1;
  // Integrators run at the PDM rate; bit 1 adds +1, bit 0 adds -1.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div   <= '0;
      pdm_clk <= 1'b0;
      r_cnt   <= '0;
      for (int i = 0; i < NUM_MICS; i++) begin
        r_i1[i]   <= '0;
        r_i2[i]   <= '0;
        r_i3[i]   <= '0;
        r_snap[i] <= '0;
      end
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) pdm_clk <= ~pdm_clk;
      if (w_strobe) r_cnt <= r_cnt + 1'b1;
      for (int i = 0; i < NUM_MICS; i++) begin
        if (w_strobe) begin
          r_i1[i] <= r_i1[i] + {{(ACC_W-1){~pdm[i]}}, 1'b1};
          r_i2[i] <= r_i2[i] + r_i1[i];
          r_i3[i] <= r_i3[i] + r_i2[i];
        end
        if (w_dec) r_snap[i] <= r_i3[i] + r_i2[i];
      end
    end
  // A frame arriving during OUT still advances the comb delays (r_drop) but its results are thrown away.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state   <= IDLE;
      r_k       <= '0;
      r_rd      <= '0;
      r_drop    <= 1'b0;
      pcm_valid <= 1'b0;
      pcm_data  <= '0;
      pcm_mic   <= '0;
      pcm_last  <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_MICS; i++) begin
        r_d1[i]  <= '0;
        r_d2[i]  <= '0;
        r_d3[i]  <= '0;
        r_buf[i] <= '0;
      end
    end else begin
      overrun <= 1'b0;
      if (w_proc) begin
        r_d1[r_k] <= r_snap[r_k];
        r_d2[r_k] <= w_c1;
        r_d3[r_k] <= w_c2;
        r_k       <= r_k == LAST ? '0 : r_k + 1'b1;
        if (r_k == LAST) r_drop <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_dec) r_state <= COMB;
        COMB: begin
          r_buf[r_k] <= w_sat;
          if (r_k == LAST) begin
            r_state   <= OUT;
            r_rd      <= '0;
            pcm_valid <= 1'b1;
            pcm_data  <= NUM_MICS == 1 ? w_sat : r_buf[0];
            pcm_mic   <= '0;
            pcm_last  <= NUM_MICS == 1;
          end
        end
        OUT: begin
          if (w_dec) begin
            overrun <= 1'b1;
            r_drop  <= 1'b1;
          end
          if (pcm_valid && pcm_ready) begin
            if (pcm_last) begin
              r_state   <= IDLE;
              pcm_valid <= 1'b0;
              pcm_last  <= 1'b0;
            end else begin
              r_rd     <= w_nxt;
              pcm_data <= r_buf[w_nxt];
              pcm_mic  <= 5'(w_nxt);
              pcm_last <= w_nxt == LAST;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule
